// File: rtl/axi_serial_uart.sv
// axi_serial_uart: full-duplex 8N1-style UART with valid/ready byte streams,
// TX/RX FIFOs, programmable bit timing, false-start rejection and
// framing-error / overrun pulses.

// Synchronous FIFO with an extra pointer MSB to tell full from empty.
module axi_serial_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0] mem_q [2**AW];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop on a full FIFO frees the slot being written this same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_q[AW-1:0]];

  // Next pointer values.
  always_comb begin
    wr_d = wr_q + (AW+1)'(do_push);
    rd_d = rd_q + (AW+1)'(do_pop);
  end

  // Pointer registers.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write.
  // NOTE: the array has no reset; the pointers alone say which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
  end
endmodule

module axi_serial_uart #(
  parameter int DIVISOR    = 868,
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              tx_ready,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              rx_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              txd,
  input  logic              rxd,
  output logic              rx_frame_err,
  output logic              rx_overrun
);
  localparam int              CW       = $clog2(DIVISOR);
  localparam logic [CW-1:0]   FULL_BIT = CW'(DIVISOR - 1);
  localparam logic [CW-1:0]   HALF_BIT = CW'(DIVISOR / 2 - 1);
  localparam int              BW       = $clog2(DATA_W);
  localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

  // ---------------- transmit path ----------------
  logic              tx_empty, tx_full, tx_pop;
  logic [DATA_W-1:0] tx_head;
  tx_state_e         tx_state_q, tx_state_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              txd_q, txd_d;

  assign tx_ready = ~tx_full;
  assign txd      = txd_q;

  axi_serial_uart_fifo #(.WIDTH(DATA_W), .AW(DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .reset(reset),
    .push(tx_valid & ~tx_full), .push_data(tx_data),
    .pop(tx_pop), .head(tx_head), .empty(tx_empty), .full(tx_full)
  );

  // Transmit FSM next state; txd follows the current state one cycle later.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: if (!tx_empty) begin
        tx_pop     = 1'b1;
        tx_shift_d = tx_head;
        tx_cnt_d   = FULL_BIT;
        tx_state_d = TX_START;
      end
      TX_START: if (tx_cnt_q == '0) begin
        tx_cnt_d   = FULL_BIT;
        tx_bit_d   = '0;
        tx_state_d = TX_DATA;
      end else tx_cnt_d = tx_cnt_q - CW'(1);
      TX_DATA: if (tx_cnt_q == '0) begin
        tx_cnt_d = FULL_BIT;
        if (tx_bit_q == LAST_BIT) tx_state_d = TX_STOP;
        else begin
          tx_bit_d   = tx_bit_q + BW'(1);
          tx_shift_d = tx_shift_q >> 1;
        end
      end else tx_cnt_d = tx_cnt_q - CW'(1);
      TX_STOP: if (tx_cnt_q == '0) begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_cnt_d   = FULL_BIT;
          tx_state_d = TX_START;
        end else tx_state_d = TX_IDLE;
      end else tx_cnt_d = tx_cnt_q - CW'(1);
      default: tx_state_d = TX_IDLE;
    endcase
    unique case (tx_state_q)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_shift_q[0];
      default:  txd_d = 1'b1;
    endcase
  end

  // Transmit registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  // ---------------- receive path ----------------
  logic              rx_s1_q, rx_s2_q, rx_s3_q, rx_fall;
  logic              rx_empty, rx_full, rx_pop, rx_push;
  logic [DATA_W-1:0] rx_head;
  rx_state_e         rx_state_q, rx_state_d;
  logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic              rx_ferr_q, rx_ferr_d, rx_ovr_q, rx_ovr_d;

  assign rx_fall      = rx_s3_q & ~rx_s2_q;
  assign rx_pop       = rx_ready & ~rx_empty;
  assign rx_valid     = ~rx_empty;
  assign rx_data      = rx_empty ? '0 : rx_head;
  assign rx_frame_err = rx_ferr_q;
  assign rx_overrun   = rx_ovr_q;

  axi_serial_uart_fifo #(.WIDTH(DATA_W), .AW(DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .reset(reset),
    .push(rx_push), .push_data(rx_shift_q),
    .pop(rx_pop), .head(rx_head), .empty(rx_empty), .full(rx_full)
  );

  // Two-flop synchroniser plus edge-detect stage, idling high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) {rx_s3_q, rx_s2_q, rx_s1_q} <= 3'b111;
    else       {rx_s3_q, rx_s2_q, rx_s1_q} <= {rx_s2_q, rx_s1_q, rxd};
  end

  // Receive FSM: mid-bit sampling, false-start rejection, stop-bit handling.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    rx_ferr_d  = 1'b0;
    rx_ovr_d   = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: if (rx_fall) begin
        rx_cnt_d   = HALF_BIT;
        rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == '0) begin
        if (rx_s2_q) rx_state_d = RX_IDLE;
        else begin
          rx_cnt_d   = FULL_BIT;
          rx_bit_d   = '0;
          rx_state_d = RX_DATA;
        end
      end else rx_cnt_d = rx_cnt_q - CW'(1);
      RX_DATA: if (rx_cnt_q == '0) begin
        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_W-1:1]};
        rx_cnt_d   = FULL_BIT;
        if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
        else rx_bit_d = rx_bit_q + BW'(1);
      end else rx_cnt_d = rx_cnt_q - CW'(1);
      RX_STOP: if (rx_cnt_q == '0) begin
        if (rx_s2_q) begin
          rx_state_d = RX_IDLE;
          if (!rx_full || rx_pop) rx_push = 1'b1;
          else rx_ovr_d = 1'b1;
        end else begin
          rx_ferr_d  = 1'b1;
          rx_state_d = RX_WAIT;
        end
      end else rx_cnt_d = rx_cnt_q - CW'(1);
      RX_WAIT: if (rx_s2_q) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receive registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end
endmodule

// File: tb/tb_axi_serial_uart.sv
// Bench for axi_serial_uart at DIVISOR=4, DATA_W=8, depth 4: TX waveform,
// loopback scoreboard, TX full, RX overrun, frame error, glitch, reset mid-frame.
module tb_axi_serial_uart;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_ready, tx_valid, rx_ready, rx_valid;
  logic [7:0] tx_data, rx_data;
  logic       txd, rxd, rx_frame_err, rx_overrun;
  logic       loop_en, rxd_drv;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_ferr = 0;
  int         n_ovr = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];

  assign rxd = loop_en ? txd : rxd_drv;

  axi_serial_uart #(.DIVISOR(DIV), .DATA_W(8), .DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .rx_ready(rx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .txd(txd), .rxd(rxd),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard side: compare every popped RX byte and count error pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) check("rx_unexpected_byte", exp_q.size(), 1);
        else check("rx_data", rx_data, exp_q.pop_front());
      end
      if (rx_frame_err) n_ferr++;
      if (rx_overrun) n_ovr++;
    end
  end

  // Offer one byte; returns #1 after the handshake edge.
  task automatic push_tx(input logic [7:0] b, input bit expect_rx);
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("push_tx_ready_timeout", n < 500, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    if (expect_rx) exp_q.push_back(b);
  endtask

  // Check one full frame on txd, starting at the next negedge.
  task automatic expect_tx(input logic [7:0] b);
    logic [9:0] frame;
    logic [3:0] s;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < DIV; c++) begin
        @(negedge clk);
        s[c] = txd;
      end
      check($sformatf("tx_%0h_bit%0d", b, i), s, frame[i] ? 4'hF : 4'h0);
    end
  endtask

  // Bit-bang a frame onto rxd with a chosen stop level.
  task automatic send_serial(input logic [7:0] d, input logic stop);
    logic [9:0] frame;
    frame = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = frame[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
    rxd_drv = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("rx_drain_remaining", exp_q.size(), 0);
  endtask

  initial begin
    int accepted, n_first, n, f0, o0;
    logic [7:0] val;
    loop_en = 1'b1; rxd_drv = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b1;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", txd, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_frame_err", rx_frame_err, 0);
    check("rst_overrun", rx_overrun, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Single TX frame: txd falls two edges after the handshake.
    push_tx(8'h55, 1);
    @(negedge clk); check("tx_lat_cycN", txd, 1);
    @(negedge clk); check("tx_lat_cycN1", txd, 1);
    expect_tx(8'h55);
    wait_drain(200);

    // Loopback, three back-to-back bytes, no idle gap.
    repeat (10) @(posedge clk);
    #1;
    push_tx(8'hA3, 1);
    push_tx(8'h00, 1);
    push_tx(8'hFF, 1);
    expect_tx(8'hA3);
    expect_tx(8'h00);
    expect_tx(8'hFF);
    wait_drain(200);
    check("loop_frame_err", n_ferr, 0);
    check("loop_overrun", n_ovr, 0);

    // TX full: hold valid while busy.
    repeat (10) @(posedge clk);
    accepted = 0; n_first = 0; val = 8'h10;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tx_data = val; tx_valid = 1'b1;
      if (tx_ready) begin
        if (accepted == 0) n_first = cyc + 1;
        exp_q.push_back(val);
        val++;
        accepted++;
      end
    end
    tx_valid = 1'b0;
    check("txfull_accepted", accepted, 5);
    check("txfull_ready_low", tx_ready, 0);
    n = 0;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("txfull_ready_rise_cycle", cyc, n_first + 41);
    wait_drain(600);

    // RX overrun: five bytes into a four-entry RX FIFO.
    repeat (10) @(posedge clk);
    #1 rx_ready = 1'b0;
    o0 = n_ovr;
    push_tx(8'h31, 1);
    push_tx(8'h32, 1);
    push_tx(8'h33, 1);
    push_tx(8'h34, 1);
    push_tx(8'h35, 0);
    repeat (260) @(posedge clk);
    #1;
    check("ovr_pulses", n_ovr - o0, 1);
    check("ovr_rx_valid", rx_valid, 1);
    check("ovr_head", rx_data, 8'h31);
    rx_ready = 1'b1;
    wait_drain(50);
    repeat (3) @(posedge clk);
    #1 check("ovr_fifo_emptied", rx_valid, 0);

    // Frame error, then a one-cycle glitch, then a good frame.
    loop_en = 1'b0;
    f0 = n_ferr; o0 = n_ovr;
    send_serial(8'hC3, 1'b0);
    repeat (60) @(posedge clk);
    #1;
    check("ferr_pulses", n_ferr - f0, 1);
    check("ferr_no_push", rx_valid, 0);
    rxd_drv = 1'b0;
    @(posedge clk);
    #1 rxd_drv = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("glitch_no_push", rx_valid, 0);
    check("glitch_no_ferr", n_ferr - f0, 1);
    check("glitch_no_ovr", n_ovr - o0, 0);
    exp_q.push_back(8'h5A);
    send_serial(8'h5A, 1'b1);
    wait_drain(200);
    check("good_after_ferr", n_ferr - f0, 1);

    // Reset mid-frame with a full TX FIFO.
    loop_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    f0 = n_ferr; o0 = n_ovr;
    push_tx(8'h96, 0);
    push_tx(8'h01, 0);
    push_tx(8'h02, 0);
    push_tx(8'h03, 0);
    push_tx(8'h04, 0);
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_tx_ready", tx_ready, 0);
    reset = 1'b1;
    #1;
    check("midrst_txd", txd, 1);
    check("midrst_tx_ready", tx_ready, 1);
    check("midrst_rx_valid", rx_valid, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    push_tx(8'h3C, 1);
    @(negedge clk);
    @(negedge clk);
    expect_tx(8'h3C);
    wait_drain(200);
    check("post_rst_ferr", n_ferr - f0, 0);
    check("post_rst_ovr", n_ovr - o0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
